// File: rtl/dac_bank_scheduler.sv
// dac_bank_scheduler
//   Double-buffered DAC playback scheduler. The sample BRAM is split into two
//   banks selected by the MSB of the read address. The active bank is streamed
//   to the DAC in a loop. Bank swaps are only taken at a loop boundary, so the
//   idle bank can be rewritten by the CPU without glitches.
//   mem_data_i packs both channels as {ch1[13:0], ch0[13:0]}.
//   Optional build macro: DAC_SCHED_IRQ_EN adds a sticky interrupt flag
//   (irq_o / irq_clr_i) that is set by swap_ack_o or done_o.

module dac_bank_scheduler #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic [ADDR_WIDTH-1:0] len0_i,
    input  logic [ADDR_WIDTH-1:0] len1_i,
    input  logic [15:0]           loops_i,
    input  logic                  swap_req_i,
    output logic                  swap_ack_o,
    output logic                  active_bank_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH:0]   mem_addr_o,
    output logic                  mem_rd_en_o,
    input  logic [27:0]           mem_data_i,
    output logic [13:0]           dac_ch0_o,
    output logic [13:0]           dac_ch1_o,
`ifdef DAC_SCHED_IRQ_EN
    output logic                  irq_o,
    input  logic                  irq_clr_i,
`endif
    output logic                  dac_valid_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Control registers
    state_t                r_state;
    logic                  r_bank;
    logic [ADDR_WIDTH-1:0] r_addr_cnt;
    logic [ADDR_WIDTH-1:0] r_len_q;
    logic [15:0]           r_loop_cnt;
    logic                  r_swap_pend;
    logic                  r_swap_ack;
    logic                  r_done;

    // Output pipeline registers
    logic                  r_rd_d1;
    logic                  r_dac_valid;
    logic [13:0]           r_dac_ch0;
    logic [13:0]           r_dac_ch1;

    // Next-state values
    state_t                w_state_next;
    logic                  w_bank_next;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [ADDR_WIDTH-1:0] w_len_next;
    logic [15:0]           w_loop_next;
    logic                  w_pend_next;
    logic                  w_ack_next;
    logic                  w_done_next;

    logic [ADDR_WIDTH-1:0] w_len_active;
    logic [ADDR_WIDTH-1:0] w_len_other;
    logic                  w_wrap;
    logic                  w_pend_eff;
    logic [15:0]           w_loop_inc;

    assign w_len_active = r_bank ? len1_i : len0_i;
    assign w_len_other  = r_bank ? len0_i : len1_i;
    assign w_wrap       = (r_addr_cnt == (r_len_q - ADDR_WIDTH'(1)));
    // A request arriving on the boundary cycle itself is honoured at that boundary
    assign w_pend_eff   = r_swap_pend | swap_req_i;
    assign w_loop_inc   = r_loop_cnt + 16'd1;

    // Next-state and control decode for the playback FSM
    always_comb begin
        w_state_next = r_state;
        w_bank_next  = r_bank;
        w_addr_next  = r_addr_cnt;
        w_len_next   = r_len_q;
        w_loop_next  = r_loop_cnt;
        w_pend_next  = r_swap_pend;
        w_ack_next   = 1'b0;
        w_done_next  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_addr_next = '0;
                // A swap in IDLE takes priority; playback starts on the next cycle
                if (swap_req_i) begin
                    w_bank_next = ~r_bank;
                    w_ack_next  = 1'b1;
                end else if (en_i && (w_len_active != '0)) begin
                    w_state_next = ST_RUN;
                    w_len_next   = w_len_active;
                    w_loop_next  = '0;
                end
            end

            ST_RUN: begin
                if (!en_i) begin
                    w_state_next = ST_IDLE;
                    w_addr_next  = '0;
                    w_pend_next  = 1'b0;
                    if (w_pend_eff) begin
                        w_bank_next = ~r_bank;
                        w_ack_next  = 1'b1;
                    end
                end else if (w_wrap) begin
                    w_addr_next = '0;
                    // Swap outranks loop-count completion at the same boundary
                    if (w_pend_eff) begin
                        w_bank_next = ~r_bank;
                        w_ack_next  = 1'b1;
                        w_pend_next = 1'b0;
                        w_len_next  = w_len_other;
                        w_loop_next = '0;
                        if (w_len_other == '0) begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_loop_next = w_loop_inc;
                        if ((loops_i != 16'd0) && (w_loop_inc == loops_i)) begin
                            w_state_next = ST_DONE;
                            w_done_next  = 1'b1;
                        end
                    end
                end else begin
                    w_addr_next = r_addr_cnt + ADDR_WIDTH'(1);
                    if (swap_req_i) begin
                        w_pend_next = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                if (swap_req_i) begin
                    w_bank_next = ~r_bank;
                    w_ack_next  = 1'b1;
                end
                if (!en_i) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_addr_next  = '0;
                w_pend_next  = 1'b0;
            end
        endcase
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bank      <= 1'b0;
            r_addr_cnt  <= '0;
            r_len_q     <= '0;
            r_loop_cnt  <= '0;
            r_swap_pend <= 1'b0;
            r_swap_ack  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_bank      <= w_bank_next;
            r_addr_cnt  <= w_addr_next;
            r_len_q     <= w_len_next;
            r_loop_cnt  <= w_loop_next;
            r_swap_pend <= w_pend_next;
            r_swap_ack  <= w_ack_next;
            r_done      <= w_done_next;
        end
    end

    // Align DAC outputs with BRAM read latency; zero the pins when no sample is present
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_d1     <= 1'b0;
            r_dac_valid <= 1'b0;
            r_dac_ch0   <= '0;
            r_dac_ch1   <= '0;
        end else begin
            r_rd_d1     <= (r_state == ST_RUN);
            r_dac_valid <= r_rd_d1;
            r_dac_ch0   <= r_rd_d1 ? mem_data_i[13:0]  : 14'd0;
            r_dac_ch1   <= r_rd_d1 ? mem_data_i[27:14] : 14'd0;
        end
    end

`ifdef DAC_SCHED_IRQ_EN
    logic r_irq;

    // Sticky interrupt flag; a new event beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else if (r_swap_ack || r_done) begin
            r_irq <= 1'b1;
        end else if (irq_clr_i) begin
            r_irq <= 1'b0;
        end
    end

    assign irq_o = r_irq;
`endif

    assign swap_ack_o    = r_swap_ack;
    assign active_bank_o = r_bank;
    assign busy_o        = (r_state == ST_RUN);
    assign done_o        = r_done;
    assign mem_addr_o    = {r_bank, r_addr_cnt};
    assign mem_rd_en_o   = (r_state == ST_RUN);
    assign dac_ch0_o     = r_dac_ch0;
    assign dac_ch1_o     = r_dac_ch1;
    assign dac_valid_o   = r_dac_valid;

endmodule

// File: tb/tb_dac_bank_scheduler.sv
// Testbench for dac_bank_scheduler: directed scenarios followed by random
// traffic, every cycle compared against a behavioural playback model.
// Define DAC_SCHED_IRQ_EN to also exercise the sticky interrupt flag.

module tb_dac_bank_scheduler;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [AW-1:0] len0 = '0;
    logic [AW-1:0] len1 = '0;
    logic [15:0]   loops = '0;
    logic          swap_req = 1'b0;
    logic          irq_clr = 1'b0;
    logic [27:0]   mem_data = '0;

    logic          swap_ack;
    logic          active_bank;
    logic          busy;
    logic          done;
    logic [AW:0]   mem_addr;
    logic          mem_rd_en;
    logic [13:0]   dac_ch0;
    logic [13:0]   dac_ch1;
    logic          dac_valid;
`ifdef DAC_SCHED_IRQ_EN
    logic          irq;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [27:0] mem [0:4095];

    dac_bank_scheduler #(.ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_i          (en),
        .len0_i        (len0),
        .len1_i        (len1),
        .loops_i       (loops),
        .swap_req_i    (swap_req),
        .swap_ack_o    (swap_ack),
        .active_bank_o (active_bank),
        .busy_o        (busy),
        .done_o        (done),
        .mem_addr_o    (mem_addr),
        .mem_rd_en_o   (mem_rd_en),
        .mem_data_i    (mem_data),
        .dac_ch0_o     (dac_ch0),
        .dac_ch1_o     (dac_ch1),
`ifdef DAC_SCHED_IRQ_EN
        .irq_o         (irq),
        .irq_clr_i     (irq_clr),
`endif
        .dac_valid_o   (dac_valid)
    );

    always #5 clk = ~clk;

    // BRAM port B: one cycle read latency
    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= mem[mem_addr];
    end

    // ---------------- behavioural model ----------------
    // mode: 0 stopped, 1 playing, 2 finished
    int m_mode, m_bank, m_pos, m_len, m_laps, m_pend;
    int m_ack, m_done, m_irq;
    int m_rd_d1, m_addr_d1, m_valid, m_dac0, m_dac1;

    function automatic int len_of(input int b);
        return (b != 0) ? int'(len1) : int'(len0);
    endfunction

    task automatic mdl_reset();
        m_mode = 0; m_bank = 0; m_pos = 0; m_len = 0; m_laps = 0; m_pend = 0;
        m_ack = 0; m_done = 0; m_irq = 0;
        m_rd_d1 = 0; m_addr_d1 = 0; m_valid = 0; m_dac0 = 0; m_dac1 = 0;
    endtask

    task automatic mdl_edge();
        logic [27:0] w;
        int want_swap;
        // the sample addressed two cycles ago reaches the pins now
        m_valid = m_rd_d1;
        w = (m_rd_d1 != 0) ? mem[m_addr_d1] : 28'd0;
        m_dac0 = int'(w[13:0]);
        m_dac1 = int'(w[27:14]);
        m_rd_d1 = (m_mode == 1) ? 1 : 0;
        m_addr_d1 = m_bank * 2048 + m_pos;
        if (m_ack != 0 || m_done != 0) m_irq = 1;
        else if (irq_clr) m_irq = 0;
        m_ack = 0;
        m_done = 0;
        want_swap = (m_pend != 0 || swap_req) ? 1 : 0;
        if (m_mode == 0) begin
            m_pos = 0;
            if (swap_req) begin
                m_bank = 1 - m_bank; m_ack = 1;
            end else if (en && len_of(m_bank) != 0) begin
                m_mode = 1; m_len = len_of(m_bank); m_laps = 0;
            end
        end else if (m_mode == 1) begin
            if (!en) begin
                m_mode = 0; m_pos = 0; m_pend = 0;
                if (want_swap != 0) begin m_bank = 1 - m_bank; m_ack = 1; end
            end else if (m_pos + 1 == m_len) begin
                m_pos = 0;
                if (want_swap != 0) begin
                    m_bank = 1 - m_bank; m_ack = 1; m_pend = 0;
                    m_len = len_of(m_bank); m_laps = 0;
                    if (m_len == 0) m_mode = 0;
                end else begin
                    m_laps = (m_laps + 1) % 65536;
                    if (loops != 0 && m_laps == int'(loops)) begin
                        m_mode = 2; m_done = 1;
                    end
                end
            end else begin
                m_pos = m_pos + 1;
                if (swap_req) m_pend = 1;
            end
        end else begin
            if (swap_req) begin m_bank = 1 - m_bank; m_ack = 1; end
            if (!en) m_mode = 0;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("swap_ack",    32'(swap_ack),    32'(m_ack));
        chk("active_bank", 32'(active_bank), 32'(m_bank));
        chk("busy",        32'(busy),        32'(m_mode == 1));
        chk("done",        32'(done),        32'(m_done));
        chk("mem_rd_en",   32'(mem_rd_en),   32'(m_mode == 1));
        chk("mem_addr",    32'(mem_addr),    32'(m_bank * 2048 + m_pos));
        chk("dac_valid",   32'(dac_valid),   32'(m_valid));
        chk("dac_ch0",     32'(dac_ch0),     32'(m_dac0));
        chk("dac_ch1",     32'(dac_ch1),     32'(m_dac1));
`ifdef DAC_SCHED_IRQ_EN
        chk("irq",         32'(irq),         32'(m_irq));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) mdl_edge();
        #1;
        check_all();
    endtask

    // async reset pulse placed mid-cycle, called right after tick()
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        check_all();
        chk("rst_addr_zero", 32'(mem_addr), 32'd0);
        #2;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        int acks;
        int dones;
        bit reached;

        for (int i = 0; i < 4096; i++) mem[i] = 28'($urandom);
        mdl_reset();

        // Reset state
        #2;
        check_all();
        #4;
        rst_n = 1'b1;
        tick();
        $display("step reset: outputs idle after reset");

        // 1: continuous loop on bank0, length 4
        len0 = 11'd4; len1 = 11'd5; loops = 16'd0; en = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_valid", 32'(dac_valid), 32'd1);
        en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        $display("step 1: bank0 loop len4");

        // 2: finite loop count
        len0 = 11'd3; loops = 16'd2; en = 1'b1;
        cnt = 0; dones = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (mem_rd_en) cnt++;
            if (done) dones++;
        end
        chk("t2_reads", 32'(cnt), 32'd6);
        chk("t2_done_pulses", 32'(dones), 32'd1);
        chk("t2_rd_en_off", 32'(mem_rd_en), 32'd0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("t2_idle", 32'(busy), 32'd0);
        $display("step 2: loops=2 gives %0d reads", cnt);

        // 3: swap at a loop boundary
        len0 = 11'd8; len1 = 11'd5; loops = 16'd0; en = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            tick();
            if (mem_addr == 12'd2) reached = 1'b1;
        end
        chk("t3_reach_addr2", 32'(reached), 32'd1);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (swap_ack) begin
                acks++;
                chk("t3_ack_addr", 32'(mem_addr), 32'h800);
            end
        end
        chk("t3_acks", 32'(acks), 32'd1);
        chk("t3_bank", 32'(active_bank), 32'd1);
        $display("step 3: swap to bank1 with %0d ack", acks);

        // 4: disable with swap pending, duplicate request ignored
        reached = 1'b0;
        for (int i = 0; i < 10 && !reached; i++) begin
            tick();
            if (mem_addr == 12'h801) reached = 1'b1;
        end
        chk("t4_reach_801", 32'(reached), 32'd1);
        acks = 0;
        swap_req = 1'b1;
        tick(); if (swap_ack) acks++;
        tick(); if (swap_ack) acks++;
        swap_req = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (swap_ack) acks++;
        end
        chk("t4_acks", 32'(acks), 32'd1);
        chk("t4_bank", 32'(active_bank), 32'd0);
        chk("t4_rd_en", 32'(mem_rd_en), 32'd0);
        $display("step 4: disable with pending swap, %0d ack", acks);

        // 5: swap into an empty bank stops playback
        len0 = 11'd4; len1 = 11'd0; en = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 10 && !reached; i++) begin
            tick();
            if (busy && mem_addr == 12'd1) reached = 1'b1;
        end
        chk("t5_reach_addr1", 32'(reached), 32'd1);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (swap_ack) acks++;
        end
        chk("t5_acks", 32'(acks), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_bank", 32'(active_bank), 32'd1);
        $display("step 5: empty bank blocks restart");

        // 6: async reset while playing bank1
        len1 = 11'd6;
        for (int i = 0; i < 5; i++) tick();
        chk("t6_busy_before", 32'(busy), 32'd1);
        async_reset();
        chk("t6_bank_after", 32'(active_bank), 32'd0);
        en = 1'b0;
        tick();
        tick();
`ifdef DAC_SCHED_IRQ_EN
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        irq_clr = 1'b1;
        tick();
        tick();
        chk("t6_irq_cleared_later", 32'(irq), 32'd0);
        swap_req = 1'b1;
        irq_clr = 1'b0;
        tick();
        swap_req = 1'b0;
        chk("t6_ack_seen", 32'(swap_ack), 32'd1);
        irq_clr = 1'b1;
        tick();
        chk("t6_irq_set_wins", 32'(irq), 32'd1);
        irq_clr = 1'b0;
`endif
        $display("step 6: async reset mid-run");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(15) != 0);
            swap_req = ($urandom_range(11) == 0);
            irq_clr = ($urandom_range(3) == 0);
            if ($urandom_range(40) == 0) begin
                len0 = AW'($urandom_range(6));
                len1 = AW'($urandom_range(6));
                loops = 16'($urandom_range(3));
            end
            tick();
            if ($urandom_range(600) == 0) async_reset();
        end
        swap_req = 1'b0;
        irq_clr = 1'b0;
        $display("step random: 3000 cycles");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
